// File: rtl/param_ram_if.sv
// Bundle of the param_ram access signals: clear request, write port, read port and status.
// parity_err is present only when PARAM_RAM_PARITY_EN is defined.
interface param_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  clr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  busy;
`ifdef PARAM_RAM_PARITY_EN
    logic                  parity_err;

    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, parity_err
    );
    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy, parity_err
    );
`else
    modport master (
        output clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );
    modport slave (
        input  clr, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
`endif
endinterface

// File: rtl/param_ram.sv
// 2**ADDR_WIDTH-word RAM that sweeps INIT_VALUE into every word after reset or clr; 1-cycle registered read, write-first.
// No backpressure: accesses are dropped while busy. PARAM_RAM_PARITY_EN adds a per-word even-parity bit and parity_err.
module param_ram #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 6,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input logic        clk,
    input logic        rst_n,
    param_ram_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdat;

    logic                  rd_fire;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The sweep owns the write port while clearing; user writes only land in READY.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdat  = bus.wr_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdat  = INIT_VALUE;
            if (bus.clr) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + ADDR_WIDTH'(1);
                if (cnt == '1) begin
                    state_nxt = READY;
                end
            end
        end else begin
            mem_we = bus.wr_en;
            if (bus.clr) begin
                state_nxt = CLEAR;
                cnt_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
    end

    assign rd_fire = (state == READY) && bus.rd_en;
    assign bypass  = bus.wr_en && (bus.wr_addr == bus.rd_addr);
    assign rd_word = bypass ? bus.wr_data : mem[bus.rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= rd_word;
            end
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = (state == CLEAR);

`ifdef PARAM_RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic rd_par;
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            par_mem[mem_waddr] <= ^mem_wdat;
        end
    end

    // A bypassed word carries freshly computed parity, so it can never flag.
    assign rd_par = bypass ? ^bus.wr_data : par_mem[bus.rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= rd_fire && (rd_par != ^rd_word);
        end
    end

    assign bus.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_param_ram.sv
// Self-checking bench for param_ram: directed scenarios plus randomized traffic against an array model.
module tb_param_ram;
    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    param_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    param_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clr     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 500) begin
            step();
            n++;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        model[a] = d;
    endtask

    task automatic test_reset();
        int n;
        idle_inputs();
        #3;
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got=%0h exp=00", bus.rd_data); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%0b exp=0", bus.rd_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_busy got=%0b exp=1", bus.busy); end
`ifdef PARAM_RAM_PARITY_EN
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got=%0b exp=0", bus.parity_err); end
`endif
        step();
        step();
        rst_n = 1'b1;
        wait_ready(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL sweep_len got=%0d exp=%0d", n, DEPTH); end
        clear_model();
        last_rd = 8'h00;
    endtask

    task automatic test_read_after_sweep();
        bus.rd_en = 1'b1; bus.rd_addr = 6'h3F;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL rd3f_valid got=%0b exp=1", bus.rd_valid); end
        checks++; if (bus.rd_data !== model[63]) begin errors++; $display("FAIL rd3f_data got=%0h exp=%0h", bus.rd_data, model[63]); end
        step();
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got=%0b exp=0", bus.rd_valid); end
        last_rd = model[63];
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [3];
        addrs[0] = 6'd0; addrs[1] = 6'd2; addrs[2] = 6'd7;
        do_write(6'd0, 8'h10);
        do_write(6'd2, 8'h11);
        do_write(6'd7, 8'hAF);
        for (int i = 0; i < 3; i++) begin
            bus.rd_en = 1'b1; bus.rd_addr = addrs[i];
            step();
            checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== model[addrs[i]]) begin
                errors++; $display("FAIL b2b_rd%0d got=%0b/%0h exp=1/%0h", i, bus.rd_valid, bus.rd_data, model[addrs[i]]);
            end
        end
        bus.rd_en = 1'b0;
        last_rd = model[7];
    endtask

    task automatic test_bypass();
        bus.wr_en = 1'b1; bus.wr_addr = 6'd5; bus.wr_data = 8'h5A;
        bus.rd_en = 1'b1; bus.rd_addr = 6'd5;
        step();
        idle_inputs();
        model[5] = 8'h5A;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5A) begin
            errors++; $display("FAIL bypass got=%0b/%0h exp=1/5a", bus.rd_valid, bus.rd_data);
        end
        last_rd = 8'h5A;
    endtask

    task automatic test_random();
        logic          we, re;
        logic [AW-1:0] wa, ra;
        logic [DW-1:0] wd, exp_d;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            re = 1'($urandom_range(0, 1));
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, DEPTH - 1));
            wd = DW'($urandom);
            if (re) exp_d = (we && wa == ra) ? wd : model[ra];
            else    exp_d = last_rd;
            bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
            bus.rd_en = re; bus.rd_addr = ra;
            step();
            if (we) model[wa] = wd;
            last_rd = exp_d;
            checks++; if (bus.rd_valid !== re || bus.rd_data !== exp_d) begin
                errors++; $display("FAIL rand_%0d got=%0b/%0h exp=%0b/%0h", i, bus.rd_valid, bus.rd_data, re, exp_d);
            end
`ifdef PARAM_RAM_PARITY_EN
            checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL rand_par_%0d got=%0b exp=0", i, bus.parity_err); end
`endif
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int n;
        int bad_valid;
        do_write(6'd3, 8'h33);
        do_write(6'd7, 8'h77);
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_busy got=%0b exp=1", bus.busy); end
        n = 0;
        bad_valid = 0;
        while (bus.busy === 1'b1 && n < 500) begin
            if (n == 10) begin
                bus.wr_en = 1'b1; bus.wr_addr = 6'd3; bus.wr_data = 8'hEE;
                bus.rd_en = 1'b1; bus.rd_addr = 6'd3;
            end else begin
                idle_inputs();
            end
            step();
            n++;
            if (bus.rd_valid !== 1'b0) bad_valid++;
        end
        idle_inputs();
        checks++; if (n != DEPTH) begin errors++; $display("FAIL clr_sweep_len got=%0d exp=%0d", n, DEPTH); end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL clr_rd_valid got=%0d pulses exp=0", bad_valid); end
        clear_model();
        bus.rd_en = 1'b1; bus.rd_addr = 6'd3;
        step();
        checks++; if (bus.rd_data !== model[3]) begin errors++; $display("FAIL clr_addr3 got=%0h exp=%0h", bus.rd_data, model[3]); end
        bus.rd_addr = 6'd7;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_data !== model[7]) begin errors++; $display("FAIL clr_addr7 got=%0h exp=%0h", bus.rd_data, model[7]); end
        last_rd = model[7];
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        do_write(6'd2, 8'h77);
        bus.rd_en = 1'b1; bus.rd_addr = 6'd2;
        step();
        bus.rd_en = 1'b0;
        bus.clr = 1'b1;
        step();
        bus.clr = 1'b0;
        repeat (30) step();
        checks++; if (bus.rd_data !== 8'h77) begin errors++; $display("FAIL hold_in_sweep got=%0h exp=77", bus.rd_data); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rd_data !== 8'h00 || bus.rd_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL mid_reset got=%0h/%0b/%0b exp=00/0/1", bus.rd_data, bus.rd_valid, bus.busy);
        end
        step();
        rst_n = 1'b1;
        wait_ready(n);
        checks++; if (n != DEPTH) begin errors++; $display("FAIL mid_reset_sweep_len got=%0d exp=%0d", n, DEPTH); end
        clear_model();
        bus.rd_en = 1'b1; bus.rd_addr = 6'd2;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== model[2]) begin
            errors++; $display("FAIL post_reset_rd got=%0b/%0h exp=1/%0h", bus.rd_valid, bus.rd_data, model[2]);
        end
        last_rd = model[2];
    endtask

`ifdef PARAM_RAM_PARITY_EN
    task automatic test_parity();
        do_write(6'd4, 8'h5B);
        do_write(6'd9, 8'h3C);
        dut.par_mem[4] = ~dut.par_mem[4];
        bus.rd_en = 1'b1; bus.rd_addr = 6'd4;
        step();
        checks++; if (bus.parity_err !== 1'b1 || bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h5B) begin
            errors++; $display("FAIL parity_bad got=%0b/%0b/%0h exp=1/1/5b", bus.parity_err, bus.rd_valid, bus.rd_data);
        end
        bus.rd_addr = 6'd9;
        step();
        bus.rd_en = 1'b0;
        checks++; if (bus.parity_err !== 1'b0 || bus.rd_valid !== 1'b1) begin
            errors++; $display("FAIL parity_clean got=%0b/%0b exp=0/1", bus.parity_err, bus.rd_valid);
        end
        step();
        checks++; if (bus.parity_err !== 1'b0) begin errors++; $display("FAIL parity_idle got=%0b exp=0", bus.parity_err); end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_read_after_sweep();
        test_back_to_back();
        test_bypass();
        test_random();
        test_clear();
        test_reset_mid_sweep();
`ifdef PARAM_RAM_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/param_ram.md
PARAM_RAM -- requirements
Module: param_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 6, sets address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 Parameter INIT_VALUE, default 0, is the DATA_WIDTH-bit word written by every clear sweep.
REQ-004 clk  input  1  is the single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  is the asynchronous, active-low reset.
REQ-006 clr  input  1  requests a clear sweep; single-cycle pulse.
REQ-007 wr_en  input  1  is the write strobe.
REQ-008 wr_addr  input  ADDR_WIDTH  is the write address.
REQ-009 wr_data  input  DATA_WIDTH  is the write data.
REQ-010 rd_en  input  1  is the read strobe.
REQ-011 rd_addr  input  ADDR_WIDTH  is the read address.
REQ-012 rd_data  output  DATA_WIDTH  is the registered read data.
REQ-013 rd_valid  output  1  marks rd_data valid for one cycle.
REQ-014 busy  output  1  is high while a clear sweep runs.
REQ-015 parity_err  output  1  flags a parity mismatch on read data (present only with PARAM_RAM_PARITY_EN).

Function
REQ-016 Control FSM SHALL have two states: CLEAR and READY.
REQ-017 In CLEAR, a counter SHALL write INIT_VALUE to address 0, 1, ..., DEPTH-1, one word per cycle; busy=1.
REQ-018 After writing address DEPTH-1, the FSM SHALL enter READY on the next edge; busy=0 from that cycle; sweep lasts exactly DEPTH cycles.
REQ-019 clr in READY SHALL enter CLEAR with counter 0 on the next edge.
REQ-020 clr in CLEAR SHALL restart the counter at 0.
REQ-021 In CLEAR, wr_en and rd_en SHALL be ignored: no user write; rd_valid stays 0.
REQ-022 In READY, wr_en=1 SHALL write wr_data to wr_addr at the rising edge.
REQ-023 In READY, rd_en=1 SHALL present mem[rd_addr] on rd_data with rd_valid=1 one cycle later (latency 1).
REQ-024 When rd_en and wr_en are both high with rd_addr==wr_addr, rd_data SHALL return the new wr_data (write-first bypass).
REQ-025 With rd_en=0, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-026 Addresses SHALL be used unmodified; no out-of-range case exists since DEPTH=2**ADDR_WIDTH.

Reset
REQ-027 rst_n=0 SHALL immediately force rd_data=0, rd_valid=0, parity_err=0, busy=1, counter=0, state=CLEAR.
REQ-028 The memory array SHALL not be reset directly; it SHALL be initialised by the sweep that starts after rst_n deasserts.
REQ-029 rst_n asserted mid-sweep or mid-read SHALL abort the operation and restart the sweep from address 0 on release.

Configuration
REQ-030 With PARAM_RAM_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on write (including sweep writes).
REQ-031 With PARAM_RAM_PARITY_EN defined, parity_err SHALL be 1 with rd_valid when stored parity mismatches recomputed parity of the read word, else 0.
REQ-032 Without PARAM_RAM_PARITY_EN, no parity storage exists and the parity_err port SHALL be absent.

Verification
REQ-033 Release rst_n at t0 -> busy=1 for exactly 64 cycles, then 0; read of addr 0x3F returns 0x00, rd_valid 1 cycle after rd_en.
REQ-034 After READY: write 0x10@0, 0x11@2, 0xAF@7; read 0, 2, 7 back-to-back -> rd_data 0x10, 0x11, 0xAF on consecutive cycles, rd_valid=1 each.
REQ-035 Same-cycle wr_en/rd_en at addr 5, wr_data 0x5A (old 0x00) -> next cycle rd_data=0x5A.
REQ-036 clr pulse after writes, then wr_en at addr 3 during busy -> write ignored, rd_valid stays 0; after 64 cycles addr 3 and 7 read 0x00.
REQ-037 rst_n pulsed low at sweep address 30 -> outputs zero immediately, busy=1; sweep restarts at 0 and completes 64 cycles later.
REQ-038 PARAM_RAM_PARITY_EN defined, stored parity bit of addr 4 force-flipped -> read of addr 4 gives parity_err=1 with rd_valid; clean addr gives 0.
